// File: rtl/exec_issue_ctrl.sv
// exec_issue_ctrl: holds a dual-lane issue pair on the ALUs until both lanes finish, then emits a one-cycle writeback
module exec_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid0,
  input  logic        in_valid1,
  input  logic [5:0]  in_alucode0,
  input  logic [5:0]  in_alucode1,
  input  logic [31:0] in_rs1data0,
  input  logic [31:0] in_rs1data1,
  input  logic [31:0] in_rs2data0,
  input  logic [31:0] in_rs2data1,
  input  logic [31:0] in_op1_0,
  input  logic [31:0] in_op1_1,
  input  logic [31:0] in_op2_0,
  input  logic [31:0] in_op2_1,
  input  logic [4:0]  in_rd0,
  input  logic [4:0]  in_rd1,
  output logic        in_ready,
  input  logic        flush,
  output logic        alu_valid0,
  output logic        alu_valid1,
  output logic [5:0]  alu_alucode0,
  output logic [5:0]  alu_alucode1,
  output logic [31:0] alu_reg_data1_0,
  output logic [31:0] alu_reg_data1_1,
  output logic [31:0] alu_reg_data2_0,
  output logic [31:0] alu_reg_data2_1,
  output logic [31:0] alu_op1_0,
  output logic [31:0] alu_op1_1,
  output logic [31:0] alu_op2_0,
  output logic [31:0] alu_op2_1,
  output logic        alu_other_busy0,
  output logic        alu_other_busy1,
  input  logic        alu_busy0,
  input  logic        alu_busy1,
  input  logic [31:0] alu_result0,
  input  logic [31:0] alu_result1,
  output logic        wb_valid0,
  output logic        wb_valid1,
  output logic [4:0]  wb_rd0,
  output logic [4:0]  wb_rd1,
  output logic [31:0] wb_data0,
  output logic [31:0] wb_data1,
  output logic [31:0] stall_cycles
);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state, state_nx;
  logic v0, v1, kill, exec, eb0, eb1, done, accept;
  logic [4:0] rd0, rd1;
  always_comb begin
    exec = state == EXEC;
    accept = state == IDLE && (in_valid0 || in_valid1) && !flush;
    eb0 = exec && v0 && alu_busy0;
    eb1 = exec && v1 && alu_busy1;
    done = exec && !eb0 && !eb1;
    state_nx = accept ? EXEC : done ? IDLE : state;
    in_ready = state == IDLE;
    alu_valid0 = exec && v0;
    alu_valid1 = exec && v1;
    alu_other_busy0 = eb1;
    alu_other_busy1 = eb0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {v0, v1, kill, rd0, rd1} <= '0;
      {alu_alucode0, alu_alucode1} <= '0;
      {alu_reg_data1_0, alu_reg_data1_1, alu_reg_data2_0, alu_reg_data2_1} <= '0;
      {alu_op1_0, alu_op1_1, alu_op2_0, alu_op2_1} <= '0;
      {wb_valid0, wb_valid1, wb_rd0, wb_rd1, wb_data0, wb_data1} <= '0;
      stall_cycles <= '0;
    end else begin
      wb_valid0 <= 1'b0;
      wb_valid1 <= 1'b0;
      if (accept) begin
        {v0, v1, rd0, rd1} <= {in_valid0, in_valid1, in_rd0, in_rd1};
        {alu_alucode0, alu_alucode1} <= {in_alucode0, in_alucode1};
        {alu_reg_data1_0, alu_reg_data1_1} <= {in_rs1data0, in_rs1data1};
        {alu_reg_data2_0, alu_reg_data2_1} <= {in_rs2data0, in_rs2data1};
        {alu_op1_0, alu_op1_1, alu_op2_0, alu_op2_1} <= {in_op1_0, in_op1_1, in_op2_0, in_op2_1};
      end
      if (exec && !done) begin
        stall_cycles <= stall_cycles + 32'd1;
        kill <= kill || flush;
      end
      // a flush landing on the completion cycle kills the writeback as well
      if (done) begin
        wb_data0 <= alu_result0;
        wb_data1 <= alu_result1;
        wb_rd0 <= rd0;
        wb_rd1 <= rd1;
        wb_valid0 <= v0 && rd0 != 5'd0 && !kill && !flush;
        wb_valid1 <= v1 && rd1 != 5'd0 && !kill && !flush;
        kill <= 1'b0;
      end
    end
endmodule

// File: tb/tb_exec_issue_ctrl.sv
// tb_exec_issue_ctrl: directed test of exec_issue_ctrl with the bench standing in for both ALUs
module tb_exec_issue_ctrl;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic [5:0] in_alucode0 = '0, in_alucode1 = '0;
  logic [31:0] in_op1_0 = '0, in_op1_1 = '0, in_op2_0 = '0, in_op2_1 = '0;
  logic [4:0] in_rd0 = '0, in_rd1 = '0;
  logic alu_busy0 = 1'b0, alu_busy1 = 1'b0;
  logic [31:0] alu_result0 = '0, alu_result1 = '0;
  logic in_ready, alu_valid0, alu_valid1, alu_other_busy0, alu_other_busy1, wb_valid0, wb_valid1;
  logic [5:0] alu_alucode0, alu_alucode1;
  logic [31:0] alu_reg_data1_0, alu_reg_data1_1, alu_reg_data2_0, alu_reg_data2_1;
  logic [31:0] alu_op1_0, alu_op1_1, alu_op2_0, alu_op2_1, wb_data0, wb_data1, stall_cycles;
  logic [4:0] wb_rd0, wb_rd1;
  int checks = 0, errors = 0;
  localparam logic [5:0] ALU_ADD = 6'd1, ALU_MUL = 6'd10, ALU_MULHU = 6'd13, ALU_DIV = 6'd14, ALU_DIVU = 6'd15;

  exec_issue_ctrl dut (
    .clk(clk), .reset(reset), .in_valid0(in_valid0), .in_valid1(in_valid1),
    .in_alucode0(in_alucode0), .in_alucode1(in_alucode1),
    .in_rs1data0(in_op1_0), .in_rs1data1(in_op1_1), .in_rs2data0(in_op2_0), .in_rs2data1(in_op2_1),
    .in_op1_0(in_op1_0), .in_op1_1(in_op1_1), .in_op2_0(in_op2_0), .in_op2_1(in_op2_1),
    .in_rd0(in_rd0), .in_rd1(in_rd1), .in_ready(in_ready), .flush(flush),
    .alu_valid0(alu_valid0), .alu_valid1(alu_valid1),
    .alu_alucode0(alu_alucode0), .alu_alucode1(alu_alucode1),
    .alu_reg_data1_0(alu_reg_data1_0), .alu_reg_data1_1(alu_reg_data1_1),
    .alu_reg_data2_0(alu_reg_data2_0), .alu_reg_data2_1(alu_reg_data2_1),
    .alu_op1_0(alu_op1_0), .alu_op1_1(alu_op1_1), .alu_op2_0(alu_op2_0), .alu_op2_1(alu_op2_1),
    .alu_other_busy0(alu_other_busy0), .alu_other_busy1(alu_other_busy1),
    .alu_busy0(alu_busy0), .alu_busy1(alu_busy1), .alu_result0(alu_result0), .alu_result1(alu_result1),
    .wb_valid0(wb_valid0), .wb_valid1(wb_valid1), .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v0, input logic [5:0] c0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] r0,
                       input logic v1, input logic [5:0] c1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] r1);
    {in_valid0, in_alucode0, in_op1_0, in_op2_0, in_rd0} = {v0, c0, a0, b0, r0};
    {in_valid1, in_alucode1, in_op1_1, in_op2_1, in_rd1} = {v1, c1, a1, b1, r1};
    tick;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_ready", in_ready, 1);
    chk("rst_alu_valid0", alu_valid0, 0);
    chk("rst_wb_valid0", wb_valid0, 0);
    chk("rst_wb_data0", wb_data0, 0);
    chk("rst_stall", stall_cycles, 0);
    #9 reset = 1'b1;
    // single-cycle ADD on lane 0, lane 1 idle
    issue(1, ALU_ADD, 5, 7, 3, 0, 0, 0, 0, 0);
    chk("add_ready_low", in_ready, 0);
    chk("add_alu_valid0", alu_valid0, 1);
    chk("add_alu_valid1", alu_valid1, 0);
    chk("add_code0", alu_alucode0, ALU_ADD);
    chk("add_op1", alu_op1_0, 5);
    chk("add_op2", alu_op2_0, 7);
    chk("add_rs2", alu_reg_data2_0, 7);
    alu_result0 = 12;
    tick;
    chk("add_wb_valid0", wb_valid0, 1);
    chk("add_wb_valid1", wb_valid1, 0);
    chk("add_wb_data0", wb_data0, 12);
    chk("add_wb_rd0", wb_rd0, 3);
    chk("add_ready", in_ready, 1);
    chk("add_stall", stall_cycles, 0);
    tick;
    chk("add_wb_pulse", wb_valid0, 0);
    // MUL on lane 0 busy for three cycles, ADD on lane 1
    issue(1, ALU_MUL, 3, 4, 5, 1, ALU_ADD, 10, 20, 6);
    alu_busy0 = 1'b1;
    alu_result1 = 30;
    #1;
    chk("mul_other_busy1", alu_other_busy1, 1);
    chk("mul_other_busy0", alu_other_busy0, 0);
    tick;
    chk("mul_stable_op1", alu_op1_0, 3);
    chk("mul_valid1_held", alu_valid1, 1);
    tick;
    tick;
    chk("mul_no_wb_yet", wb_valid0, 0);
    alu_busy0 = 1'b0;
    alu_result0 = 12;
    #1;
    chk("mul_done_valid0", alu_valid0, 1);
    chk("mul_done_other_busy1", alu_other_busy1, 0);
    tick;
    chk("mul_wb_valid0", wb_valid0, 1);
    chk("mul_wb_valid1", wb_valid1, 1);
    chk("mul_wb_data0", wb_data0, 12);
    chk("mul_wb_data1", wb_data1, 30);
    chk("mul_wb_rd1", wb_rd1, 6);
    chk("mul_stall", stall_cycles, 3);
    chk("mul_idle_valid0", alu_valid0, 0);
    tick;
    chk("mul_wb_pulse0", wb_valid0, 0);
    chk("mul_wb_pulse1", wb_valid1, 0);
    // DIVU busy two cycles, MULHU busy one cycle
    issue(1, ALU_DIVU, 100, 7, 7, 1, ALU_MULHU, 32'hFFFF_FFFF, 2, 8);
    alu_busy0 = 1'b1;
    alu_busy1 = 1'b1;
    #1;
    chk("div_ready_c1", in_ready, 0);
    chk("div_other_busy0", alu_other_busy0, 1);
    tick;
    alu_busy1 = 1'b0;
    alu_result1 = 1;
    #1;
    chk("div_ready_c2", in_ready, 0);
    chk("div_other_busy0_off", alu_other_busy0, 0);
    tick;
    alu_busy0 = 1'b0;
    alu_result0 = 14;
    #1;
    chk("div_ready_c3", in_ready, 0);
    tick;
    chk("div_wb_valid0", wb_valid0, 1);
    chk("div_wb_valid1", wb_valid1, 1);
    chk("div_wb_data0", wb_data0, 14);
    chk("div_wb_data1", wb_data1, 1);
    chk("div_stall", stall_cycles, 5);
    // DIV by zero killed by a flush in its second EXEC cycle
    issue(1, ALU_DIV, 9, 0, 9, 0, 0, 0, 0, 0);
    alu_busy0 = 1'b1;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    chk("kill_still_driving", alu_valid0, 1);
    tick;
    alu_busy0 = 1'b0;
    alu_result0 = 32'hFFFF_FFFF;
    tick;
    chk("kill_wb_valid0", wb_valid0, 0);
    chk("kill_ready", in_ready, 1);
    chk("kill_stall", stall_cycles, 8);
    // flush while idle refuses the pair
    in_valid0 = 1'b1;
    flush = 1'b1;
    tick;
    chk("idle_flush_ready", in_ready, 1);
    chk("idle_flush_valid0", alu_valid0, 0);
    flush = 1'b0;
    in_valid0 = 1'b0;
    issue(1, ALU_ADD, 1, 1, 1, 0, 0, 0, 0, 0);
    alu_result0 = 2;
    tick;
    chk("post_kill_wb_valid0", wb_valid0, 1);
    chk("post_kill_wb_data0", wb_data0, 2);
    // flush arriving on the completion cycle itself
    issue(1, ALU_ADD, 4, 4, 2, 0, 0, 0, 0, 0);
    alu_result0 = 8;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_done_wb_valid0", wb_valid0, 0);
    chk("flush_done_ready", in_ready, 1);
    tick;
    chk("flush_done_kill_clear_ready", in_ready, 1);
    // rd=0 on lane 1 never writes back
    issue(0, 0, 0, 0, 0, 1, ALU_ADD, 2, 3, 0);
    alu_result1 = 5;
    tick;
    chk("rd0_wb_valid1", wb_valid1, 0);
    chk("rd0_wb_valid0", wb_valid0, 0);
    chk("rd0_stall", stall_cycles, 8);
    // asynchronous reset in the middle of a multiply
    issue(1, ALU_MUL, 9, 9, 4, 0, 0, 0, 0, 0);
    alu_busy0 = 1'b1;
    tick;
    #1 reset = 1'b0;
    #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_alu_valid0", alu_valid0, 0);
    chk("arst_op1", alu_op1_0, 0);
    chk("arst_code0", alu_alucode0, 0);
    chk("arst_stall", stall_cycles, 0);
    chk("arst_wb_data0", wb_data0, 0);
    chk("arst_wb_rd0", wb_rd0, 0);
    #1 reset = 1'b1;
    alu_busy0 = 1'b0;
    tick;
    chk("arst_release_wb", wb_valid0, 0);
    chk("arst_release_ready", in_ready, 1);
    issue(1, ALU_MUL, 6, 7, 10, 0, 0, 0, 0, 0);
    alu_busy0 = 1'b1;
    tick;
    tick;
    alu_busy0 = 1'b0;
    alu_result0 = 42;
    tick;
    chk("mul42_wb_valid0", wb_valid0, 1);
    chk("mul42_wb_data0", wb_data0, 42);
    chk("mul42_wb_rd0", wb_rd0, 10);
    chk("mul42_stall", stall_cycles, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_issue_ctrl.md
EXEC_ISSUE_CTRL -- requirements
Module: exec_issue_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 in_valid0 / in_valid1  input  1 each  issue-slot lane valid from decode.
REQ-004 in_alucode0 / in_alucode1  input  6 each  ALU operation code (ALU_* encodings).
REQ-005 in_rs1data0/1, in_rs2data0/1, in_op1_0/1, in_op2_0/1  input  32 each  register and operand data per lane.
REQ-006 in_rd0 / in_rd1  input  5 each  destination register per lane.
REQ-007 in_ready  output  1  high when a new pair may be accepted.
REQ-008 flush  input  1  kill the current or pending pair.
REQ-009 alu_valid0/1, alu_alucode0/1, alu_reg_data1_0/1, alu_reg_data2_0/1, alu_op1_0/1, alu_op2_0/1  output  1/6/32 each  held drive to each ALU lane.
REQ-010 alu_other_busy0 / alu_other_busy1  output  1 each  busy of the opposite lane.
REQ-011 alu_busy0/1 input 1 each; alu_result0/1 input 32 each  ALU lane status and result.
REQ-012 wb_valid0/1 output 1 each; wb_rd0/1 output 5 each; wb_data0/1 output 32 each  one-cycle writeback.
REQ-013 stall_cycles  output  32  count of EXEC cycles beyond the first.

Function
REQ-014 FSM states SHALL be IDLE and EXEC only; in_ready SHALL equal (state==IDLE).
REQ-015 In IDLE, when in_valid0|in_valid1 and !flush, the block SHALL latch all lane inputs plus per-lane valid bits and enter EXEC next cycle.
REQ-016 In IDLE with flush high, no pair SHALL be accepted.
REQ-017 In EXEC, alu_validN SHALL equal the latched lane-N valid; the ALU operand outputs SHALL equal latched values and stay stable for the whole of EXEC.
REQ-018 Effective busy per lane SHALL be alu_busyN & latched_validN; an invalid lane SHALL count as not busy.
REQ-019 alu_other_busy0 SHALL equal effective busy of lane 1 and vice versa, combinationally.
REQ-020 Completion cycle: the first EXEC cycle with both effective busy low; alu_valid SHALL remain asserted during it so the ALUs return to their idle state.
REQ-021 On the completion cycle, wb_dataN<=alu_resultN and wb_rdN<=latched rd; wb_validN SHALL pulse high for exactly the following cycle when lane N was valid, latched rd!=0 and the pair is not killed; state SHALL then return to IDLE.
REQ-022 Single-cycle ops: EXEC lasts 1 cycle; latency from accept to wb_valid SHALL be 2 cycles.
REQ-023 flush during EXEC SHALL set a kill flag; the block SHALL keep driving the ALUs until the completion cycle, then suppress both wb_valid outputs; kill SHALL clear on return to IDLE.
REQ-024 Simultaneous flush and completion SHALL suppress wb_valid.
REQ-025 stall_cycles SHALL increment by 1 on every EXEC cycle that is not the completion cycle, wrapping 0xFFFFFFFF to 0.
REQ-026 Outside EXEC, alu_valid0/1 and alu_other_busy0/1 SHALL be 0.

Reset
REQ-027 On reset low, immediately: state=IDLE, in_ready=1, all alu_* outputs=0, wb_valid0/1=0, wb_rd=0, wb_data=0, stall_cycles=0, kill=0, latched data=0.
REQ-028 Reset asserted mid-EXEC SHALL abort the pair with no wb_valid; release SHALL resume in IDLE.

Verification
REQ-029 Lane0 ADD 5+7, lane1 invalid -> EXEC 1 cycle, wb_valid0=1 with wb_data0=12 two cycles after accept, wb_valid1=0, stall_cycles=0.
REQ-030 Lane0 MUL 3*4, lane1 ADD -> alu_other_busy1=1 while multiply busy; single wb pulse with wb_data0=12, both lanes together; stall_cycles equals multiply busy cycle count.
REQ-031 Lane0 DIVU 100/7, lane1 MULHU 0xFFFFFFFF*2 -> wb_data0=14, wb_data1=1 in the same cycle; in_ready low throughout EXEC.
REQ-032 DIV by 0 with flush pulsed in the 2nd EXEC cycle -> no wb_valid; in_ready returns to 1; next ADD 1+1 produces 2.
REQ-033 Lane1 ADD with rd=0 -> wb_valid1 stays 0.
REQ-034 Reset mid-MUL -> all outputs at reset values asynchronously; after release, next MUL 6*7 produces 42.
